tank_level_model: RTL



---
 rtl/tank_level_model_pkg.sv | 33 +++
 rtl/tank_level_model_tick_prescaler.sv | 31 +++
 rtl/tank_level_model.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tank_level_model_pkg.sv
// Shared definitions for the two-pump tank plant model.
//   - Bit indexes into the pump command and level sensor vectors.
//   - Level sensor codes, including the physically impossible fault code.
//   - Water-region state encoding and its mapping onto the sensor code.
package tank_pkg;

    localparam int SENSOR_I = 0;
    localparam int SENSOR_S = 1;
    localparam int PUMP_B1  = 0;
    localparam int PUMP_B2  = 1;

    localparam logic [1:0] SENS_BELOW = 2'b00;
    localparam logic [1:0] SENS_MID   = 2'b01;
    localparam logic [1:0] SENS_ABOVE = 2'b11;
    localparam logic [1:0] SENS_FAULT = 2'b10;  // S wet while I dry: cannot happen physically

    typedef enum logic [1:0] {
        REG_EMPTY = 2'd0,
        REG_LOW   = 2'd1,
        REG_MID   = 2'd2,
        REG_HIGH  = 2'd3
    } region_t;

    // EMPTY and LOW are indistinguishable to the sensors.
    function automatic logic [1:0] sensor_code(input region_t r);
        case (r)
            REG_MID:  return SENS_MID;
            REG_HIGH: return SENS_ABOVE;
            default:  return SENS_BELOW;
        endcase
    endfunction

endpackage

// File: rtl/tank_level_model_tick_prescaler.sv
// tick_prescaler: free-running modulo-TICK_DIV counter producing a one-clock
// tick on the last count of each period.
//   clock : system clock, rising edge
//   reset : synchronous, active-high; restarts the period at count 0
//   tick  : high while the count equals TICK_DIV-1 (always high for TICK_DIV=1)
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/tank_level_model.sv
// tank_level_model: synthesizable plant model of the two-pump tank.
// Integrates a water level once per prescaled tick from pump inflow and a
// switchable drain, clamps it to [0, LEVEL_MAX] with sticky alarms, counts
// per-pump run ticks, and reports the I/S level sensor pair.
//   clock         : system clock, rising edge
//   reset         : synchronous, active-high, overrides every other input
//   pumps         : bit0 = B1 running, bit1 = B2 running (sampled on ticks)
//   drain_enable  : consumer draw active (sampled on ticks)
//   fault_inject  : forces level_sensors to the impossible code 2'b10
//   level_sensors : bit0 = I sensor, bit1 = S sensor
//   level         : current water level
//   overflow      : sticky, inflow was clipped at LEVEL_MAX
//   dry           : sticky, drain was clipped at 0
//   b1_ticks      : ticks with B1 on, saturating
//   b2_ticks      : ticks with B2 on, saturating
module tank_level_model
    import tank_pkg::*;
#(
    parameter int LEVEL_W    = 8,
    parameter int LEVEL_MAX  = 200,
    parameter int I_LEVEL    = 64,
    parameter int S_LEVEL    = 160,
    parameter int PUMP_RATE  = 2,
    parameter int DRAIN_RATE = 3,
    parameter int TICK_DIV   = 4,
    parameter int INIT_LEVEL = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         pumps,
    input  logic               drain_enable,
    input  logic               fault_inject,
    output logic [1:0]         level_sensors,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic               dry,
    output logic [15:0]        b1_ticks,
    output logic [15:0]        b2_ticks
);

    // Three extra bits cover a sign plus two pumps' worth of headroom above
    // LEVEL_MAX without the intermediate sum wrapping.
    localparam int SUM_W = LEVEL_W + 3;
    typedef logic signed [SUM_W-1:0] sum_t;

    localparam sum_t PUMP_S  = sum_t'(PUMP_RATE);
    localparam sum_t DRAIN_S = sum_t'(DRAIN_RATE);
    localparam sum_t LMAX_S  = sum_t'(LEVEL_MAX);

    localparam logic [LEVEL_W-1:0] INIT_L = LEVEL_W'(INIT_LEVEL);
    localparam logic [LEVEL_W-1:0] MAX_L  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] I_L    = LEVEL_W'(I_LEVEL);
    localparam logic [LEVEL_W-1:0] S_L    = LEVEL_W'(S_LEVEL);

    function automatic logic [LEVEL_W-1:0] clamp_level(input sum_t s);
        if (s[SUM_W-1]) begin
            return '0;
        end else if (s > LMAX_S) begin
            return MAX_L;
        end else begin
            return s[LEVEL_W-1:0];
        end
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic region_t region_of(input logic [LEVEL_W-1:0] l);
        if (l == '0) begin
            return REG_EMPTY;
        end else if (l < I_L) begin
            return REG_LOW;
        end else if (l < S_L) begin
            return REG_MID;
        end else begin
            return REG_HIGH;
        end
    endfunction

    logic               w_tick;
    sum_t               w_inflow;
    sum_t               w_outflow;
    sum_t               w_sum;
    logic [LEVEL_W-1:0] w_level_next;
    logic               w_clip_high;
    logic               w_clip_low;

    logic [LEVEL_W-1:0] r_level;
    region_t            r_region;
    logic               r_fault;
    logic               r_overflow;
    logic               r_dry;
    logic [15:0]        r_b1_ticks;
    logic [15:0]        r_b2_ticks;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (w_tick)
    );

    // Pump and drain net out before clamping, so opposing flows that stay
    // in range raise no alarm.
    always_comb begin
        w_inflow  = '0;
        w_outflow = '0;
        if (pumps[PUMP_B1]) w_inflow = w_inflow + PUMP_S;
        if (pumps[PUMP_B2]) w_inflow = w_inflow + PUMP_S;
        if (drain_enable)   w_outflow = DRAIN_S;
        w_sum        = sum_t'({3'b000, r_level}) + w_inflow - w_outflow;
        w_level_next = w_tick ? clamp_level(w_sum) : r_level;
        w_clip_high  = w_tick && !w_sum[SUM_W-1] && (w_sum > LMAX_S);
        w_clip_low   = w_tick && w_sum[SUM_W-1];
    end

    // Region FSM is driven from the level being written this edge, so the
    // sensor code moves on the same edge as the level itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level    <= INIT_L;
            r_region   <= region_of(INIT_L);
            r_fault    <= 1'b0;
            r_overflow <= 1'b0;
            r_dry      <= 1'b0;
            r_b1_ticks <= '0;
            r_b2_ticks <= '0;
        end else begin
            r_level  <= w_level_next;
            r_region <= region_of(w_level_next);
            r_fault  <= fault_inject;
            if (w_clip_high) r_overflow <= 1'b1;
            if (w_clip_low)  r_dry      <= 1'b1;
            if (w_tick && pumps[PUMP_B1]) r_b1_ticks <= sat_inc(r_b1_ticks);
            if (w_tick && pumps[PUMP_B2]) r_b2_ticks <= sat_inc(r_b2_ticks);
        end
    end

    assign level_sensors = r_fault ? SENS_FAULT : sensor_code(r_region);
    assign level         = r_level;
    assign overflow      = r_overflow;
    assign dry           = r_dry;
    assign b1_ticks      = r_b1_ticks;
    assign b2_ticks      = r_b2_ticks;

endmodule
